alu_cmd_sequencer: RTL and testbench

Initiator-side front end for the 8-bit combinational ALU. It accepts operation requests over a valid/ready stream and buffers them in a small command FIFO. It drives each request onto the ALU operand/command port from registers, captures `result`/`ovr` one cycle later, and returns them on a valid/ready response stream. It also keeps a sticky overflow flag and a completed-operation counter for the control plane.

---
 rtl/alu_cmd_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Initiator-side front end for an 8-bit combinational ALU. Requests arrive on
//   a valid/ready stream and are buffered in a DEPTH-entry command FIFO. Each
//   entry is popped into registered ALU operand/command outputs. The ALU
//   result is captured one cycle later and returned on a valid/ready response
//   stream. A sticky overflow flag and a wrapping completed-operation counter
//   are kept for the control plane.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (ready = FIFO not full)
//   req_cmd/req_a/req_b           request command and operands
//   alu_a/alu_b/alu_cmd           registered drive to the ALU
//   alu_result/alu_ovr            ALU return (combinational from alu_*)
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/rsp_ovr/rsp_cmd    captured response
//   ovr_sticky/ovr_clr            sticky overflow flag and its clear
//   op_count                      completed response handshakes, wraps
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_cmd,
    input  logic [7:0]       alu_result,
    input  logic             alu_ovr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_ovr,
    output logic [1:0]       rsp_cmd,
    output logic             ovr_sticky,
    input  logic             ovr_clr,
    output logic [CNT_W-1:0] op_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [17:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic [7:0]         r_alu_a;
    logic [7:0]         r_alu_b;
    logic [1:0]         r_alu_cmd;
    logic               r_rsp_valid;
    logic [7:0]         r_rsp_result;
    logic               r_rsp_ovr;
    logic [1:0]         r_rsp_cmd;
    logic               r_ovr_sticky;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_rsp_hs;
    logic [17:0]        w_head;

    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    // Full blocks the push even if a pop frees a slot on the same edge.
    assign w_push    = req_valid && !w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_capture = (r_state == S_DRIVE);
    assign w_rsp_hs  = (r_state == S_HOLD) && rsp_ready;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (rsp_ready) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = S_DRIVE;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FIFO storage carries only data, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_cmd, req_a, req_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_cmd    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_ovr    <= 1'b0;
            r_rsp_cmd    <= '0;
            r_ovr_sticky <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_state <= w_next_state;

            // Power-of-two depth lets the pointers wrap naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_alu_cmd <= w_head[17:16];
                r_alu_a   <= w_head[15:8];
                r_alu_b   <= w_head[7:0];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_capture) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= alu_result;
                r_rsp_ovr    <= alu_ovr;
                r_rsp_cmd    <= r_alu_cmd;
            end else if (w_rsp_hs) begin
                r_rsp_valid  <= 1'b0;
            end

            if (w_rsp_hs) begin
                r_op_count <= r_op_count + 1'b1;
            end

            // Set takes priority over a coincident clear.
            if (w_capture && alu_ovr) begin
                r_ovr_sticky <= 1'b1;
            end else if (ovr_clr) begin
                r_ovr_sticky <= 1'b0;
            end
        end
    end

    assign req_ready  = !w_full;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_cmd    = r_alu_cmd;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_ovr    = r_rsp_ovr;
    assign rsp_cmd    = r_rsp_cmd;
    assign ovr_sticky = r_ovr_sticky;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_cmd = '0;
    logic [7:0]  req_a = '0;
    logic [7:0]  req_b = '0;
    logic        rsp_ready = 1'b0;
    logic        ovr_clr = 1'b0;

    logic        req_ready, rsp_valid, rsp_ovr, ovr_sticky, alu_ovr;
    logic [7:0]  alu_a, alu_b, alu_result, rsp_result, op_count;
    logic [1:0]  alu_cmd, rsp_cmd;

    logic        req_ready2, rsp_valid2, rsp_ovr2, ovr_sticky2, alu_ovr2;
    logic [7:0]  alu_a2, alu_b2, alu_result2, rsp_result2;
    logic [1:0]  alu_cmd2, rsp_cmd2, op_count2;

    always #5 clk = ~clk;

    // Reference ALU: 8-bit modulo result, bit 8 is carry (add) or borrow (sub).
    function automatic logic [8:0] alu_fn(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            2'd0:    return {1'b0, a};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a} + {1'b0, b};
            default: return {1'b0, b} + {1'b0, b};
        endcase
    endfunction

    assign {alu_ovr, alu_result}   = alu_fn(alu_cmd, alu_a, alu_b);
    assign {alu_ovr2, alu_result2} = alu_fn(alu_cmd2, alu_a2, alu_b2);

    alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
        .alu_result(alu_result), .alu_ovr(alu_ovr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_ovr(rsp_ovr), .rsp_cmd(rsp_cmd),
        .ovr_sticky(ovr_sticky), .ovr_clr(ovr_clr), .op_count(op_count)
    );

    // Narrow-counter instance sharing all stimulus, for the wrap check.
    alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready2),
        .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_cmd(alu_cmd2),
        .alu_result(alu_result2), .alu_ovr(alu_ovr2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result2), .rsp_ovr(rsp_ovr2), .rsp_cmd(rsp_cmd2),
        .ovr_sticky(ovr_sticky2), .ovr_clr(ovr_clr), .op_count(op_count2)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: queue of outstanding responses {cmd, ovr, result}
    // in request order, plus the expected counter and sticky flag.
    logic [10:0] q[$];
    logic [7:0]  exp_cnt = '0;
    logic        exp_sticky = 1'b0;
    logic        prev_valid = 1'b0;
    int          stall = 0;
    logic        m_acc, m_hs, m_clr, m_hold;
    logic [1:0]  m_c;
    logic [7:0]  m_a, m_b;

    always begin
        @(posedge clk);
        m_acc  = rst_n && req_valid && req_ready;
        m_hs   = rst_n && rsp_valid && rsp_ready;
        m_hold = rst_n && rsp_valid && !rsp_ready;
        m_clr  = ovr_clr;
        m_c    = req_cmd;
        m_a    = req_a;
        m_b    = req_b;
        #1;
        if (!rst_n) begin
            q.delete();
            exp_cnt    = '0;
            exp_sticky = 1'b0;
            prev_valid = 1'b0;
            stall      = 0;
        end else begin
            if (m_hs) begin
                if (q.size() > 0) void'(q.pop_front());
                exp_cnt = exp_cnt + 8'd1;
            end
            if (m_acc) q.push_back({m_c, alu_fn(m_c, m_a, m_b)});
            if (rsp_valid && !prev_valid && q.size() > 0 && q[0][8])
                exp_sticky = 1'b1;
            else if (m_clr)
                exp_sticky = 1'b0;

            if (rsp_valid) begin
                if (q.size() == 0) chk("rsp_spurious", 1, 0);
                else begin
                    chk("rsp_result", rsp_result, q[0][7:0]);
                    chk("rsp_ovr", rsp_ovr, q[0][8]);
                    chk("rsp_cmd", rsp_cmd, q[0][10:9]);
                end
            end
            if (rsp_valid2) begin
                if (q.size() == 0) chk("w2_rsp_spurious", 1, 0);
                else chk("w2_rsp", {rsp_cmd2, rsp_ovr2, rsp_result2}, q[0]);
            end
            if (m_hold) chk("rsp_hold_valid", rsp_valid, 1);
            chk("req_ready", req_ready, q.size() < DEPTH + 1);
            chk("w2_req_ready", req_ready2, q.size() < DEPTH + 1);
            chk("op_count", op_count, exp_cnt);
            chk("w2_op_count", op_count2, exp_cnt[1:0]);
            chk("ovr_sticky", ovr_sticky, exp_sticky);
            chk("w2_ovr_sticky", ovr_sticky2, exp_sticky);

            if (q.size() > 0 && !rsp_valid) stall++;
            else stall = 0;
            if (stall > 2) begin
                chk("rsp_stall", stall, 0);
                stall = 0;
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        ovr_clr = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_ovr", rsp_ovr, 0);
        chk("rst_rsp_cmd", rsp_cmd, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_cmd", alu_cmd, 0);
        chk("rst_ovr_sticky", ovr_sticky, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_op_count_w2", op_count2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
        int t;
        t = 0;
        req_valid = 1'b1;
        req_cmd = c;
        req_a = a;
        req_b = b;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !rsp_valid) return;
        end
        chk("drain_timeout", 0, 1);
    endtask

    logic [1:0] t_cmd [3] = '{2'd1, 2'd3, 2'd0};
    logic [7:0] t_a   [3] = '{8'd5, 8'd0, 8'h5A};
    logic [7:0] t_b   [3] = '{8'd10, 8'd128, 8'd0};
    logic [7:0] t_res [3] = '{8'd251, 8'd0, 8'h5A};
    logic       t_ovr [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        int got, last, acc;
        repeat (2) @(negedge clk);
        do_reset();

        // Single op: 200+100 -> 44 with carry, valid two edges after accept.
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_cmd = 2'd2; req_a = 8'd200; req_b = 8'd100;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("lat_e1_valid", rsp_valid, 0);
        @(negedge clk);
        chk("lat_e2_valid", rsp_valid, 1);
        chk("single_result", rsp_result, 44);
        chk("single_ovr", rsp_ovr, 1);
        chk("single_cmd", rsp_cmd, 2);
        chk("single_sticky", ovr_sticky, 1);
        @(negedge clk);
        chk("single_op_count", op_count, 1);

        // Back-to-back: in order at one response per two cycles.
        got = 0; last = -1;
        for (int cy = 0; cy < 20; cy++) begin
            if (cy < 3) begin
                req_valid = 1'b1; req_cmd = t_cmd[cy]; req_a = t_a[cy]; req_b = t_b[cy];
            end else req_valid = 1'b0;
            @(negedge clk);
            if (rsp_valid && got < 3) begin
                chk("b2b_result", rsp_result, t_res[got]);
                chk("b2b_ovr", rsp_ovr, t_ovr[got]);
                if (got > 0) chk("b2b_spacing", cy - last, 2);
                last = cy;
                got++;
            end
        end
        chk("b2b_count", got, 3);

        // Back-pressure: exactly DEPTH+1 accepted, then drain all in order.
        do_reset();
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_cmd = 2'($urandom_range(0, 3));
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            if (req_ready) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        repeat (3) @(negedge clk);
        chk("bp_hold_valid", rsp_valid, 1);
        drain();
        chk("bp_op_count", op_count, 5);
        chk("wrap_op_count_w2", op_count2, 1);

        // Sticky flag.
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("sticky_clr_alone", ovr_sticky, 0);
        send(2'd0, 8'd1, 8'd0);
        drain();
        chk("sticky_no_ovr", ovr_sticky, 0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_cmd = 2'd2; req_a = 8'd255; req_b = 8'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("sticky_set_wins", ovr_sticky, 1);
        chk("sticky_cap_result", rsp_result, 0);
        drain();
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("sticky_clr_again", ovr_sticky, 0);

        // Reset with one response held and three queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd2, 8'(i + 1), 8'd200);
        repeat (3) @(negedge clk);
        chk("mid_hold_valid", rsp_valid, 1);
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", rsp_valid, 0);
        end
        send(2'd1, 8'd100, 8'd1);
        begin
            int t;
            t = 0;
            while (!rsp_valid && t < 10) begin
                @(negedge clk);
                t++;
            end
            chk("post_rst_valid", rsp_valid, 1);
            chk("post_rst_result", rsp_result, 99);
            chk("post_rst_ovr", rsp_ovr, 0);
        end
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_cmd = 2'($urandom_range(0, 3));
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            ovr_clr = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        ovr_clr = 1'b0;
        drain();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
